// File: rtl/gate_bist_if.sv
// Control/result bundle between the BIST engine and its host.
// The gate under test is fed from stim and answers on dut_out.
interface gate_bist_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [2:0]       mode;
    logic             dut_out;
    logic [N_IN-1:0]  stim;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [N_IN-1:0]  first_err_vec;
    logic             first_err_valid;

    modport master (
        output start, mode, dut_out,
        input  stim, busy, done, pass,
        input  err_count, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, mode, dut_out,
        output stim, busy, done, pass,
        output err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_bist.sv
// Exhaustive-sweep self-test engine for basic N-input gates.
// Drives every input vector, waits SETTLE cycles, compares against a golden gate.
module gate_bist #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input logic        clk,
    input logic        rst_n,
    gate_bist_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_e;

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] RELOAD = WW'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [2:0]       mode_q, mode_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fev_q, fev_d;
    logic             fvalid_q, fvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             golden;
    logic             mismatch;
    logic [ERR_W-1:0] err_upd;

    always_comb begin
        golden = 1'b0;
        unique case (mode_q)
            3'd0: golden = &stim_q;
            3'd1: golden = |stim_q;
            3'd2: golden = ~&stim_q;
            3'd3: golden = ~|stim_q;
            3'd4: golden = ^stim_q;
            3'd5: golden = ~^stim_q;
            3'd6: golden = ~stim_q[0];
            3'd7: golden = stim_q[0];
        endcase
    end

    assign mismatch = (bus.dut_out != golden);

    // Counter sticks at all-ones once saturated.
    assign err_upd = (mismatch && (err_q != '1))
                   ? err_q + ERR_W'(1) : err_q;

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        wait_d   = wait_q;
        mode_d   = mode_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fvalid_d = fvalid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    err_d    = '0;
                    fev_d    = '0;
                    fvalid_d = 1'b0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    stim_d   = '0;
                    busy_d   = 1'b1;
                    wait_d   = RELOAD;
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                if (wait_q == '0) state_d = SAMPLE;
                else wait_d = wait_q - WW'(1);
            end
            SAMPLE: begin
                err_d = err_upd;
                if (mismatch && !fvalid_q) begin
                    fev_d    = stim_q;
                    fvalid_d = 1'b1;
                end
                // Terminal check before increment keeps stim from wrapping.
                if (&stim_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_upd == '0);
                    state_d = DONE;
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    wait_d  = RELOAD;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stim_q   <= '0;
            wait_q   <= '0;
            mode_q   <= '0;
            err_q    <= '0;
            fev_q    <= '0;
            fvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            wait_q   <= wait_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fvalid_q <= fvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.stim            = stim_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = fev_q;
    assign bus.first_err_valid = fvalid_q;
endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Parametrised built-in self-test engine for the basic-gate library; the hardware successor to the per-gate stimulus benches.
- Sweeps all 2^N_IN input combinations into an external N-input gate under test and samples its output after a settle delay.
- Compares each sample against an internal golden model of the selected gate function and reports pass/fail, mismatch count and the first failing vector.
- Sits beside any gate instance; one engine can test AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF variants.

Parameters:
- N_IN, 2, number of gate inputs; legal range 2..8.
- SETTLE, 1, cycles between driving a vector and sampling dut_out; legal range >=1.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only when busy=0.
- mode  input  3  gate function, latched on an accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT of bit0, 7 BUF of bit0.
- dut_out  input  1  output of the gate under test.
- stim  output  N_IN  registered vector driven to the gate inputs.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid while done=1; high iff err_count==0.
- err_count  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- first_err_vec  output  N_IN  stim value of the first mismatch; meaningful only when first_err_valid=1.
- first_err_valid  output  1  high once any mismatch has been recorded in the current sweep.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (all outputs): stim=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0; FSM enters IDLE. Reset asserted mid-sweep aborts immediately to these values; no partial result is retained.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE or DONE with start=1:
  - Latch mode, clear err_count, first_err_valid, first_err_vec, done and pass.
  - Set stim=0, busy=1, load wait counter with SETTLE-1, go to APPLY.
- APPLY: if wait counter=0, go to SAMPLE; otherwise decrement.
- SAMPLE:
  - Compare dut_out with golden(latched mode, stim). Golden reductions for modes 0-5 span all N_IN bits; modes 6 and 7 use stim[0] only.
  - On mismatch: increment err_count unless already saturated. If first_err_valid=0, capture first_err_vec=stim and set first_err_valid=1.
  - If stim equals all-ones: go to DONE with busy=0, done=1, and pass = (updated err_count==0), including the final sample's result.
  - Otherwise: stim=stim+1, reload wait counter, go to APPLY.
- Timing: each vector takes SETTLE+1 cycles. done rises 2^N_IN*(SETTLE+1) cycles after the start edge. stim holds its final value in DONE.
- start while busy=1 is ignored. Changes on mode while busy=1 are ignored.
- DONE holds all results until reset or an accepted start.
- Counter width: stim increments wrap-free because the terminal check precedes the increment.

Test Plan:
- N_IN=2, SETTLE=1, mode=2, dut_out driven by a correct NAND of stim -> stim sequence 00,01,10,11; done rises 8 cycles after start; pass=1, err_count=0, first_err_valid=0.
- Same setup, but the DUT is an AND gate -> all 4 vectors mismatch; err_count=4, first_err_vec=2'b00, first_err_valid=1, pass=0.
- Same setup, dut_out stuck at 1 -> mismatch only at stim=11; err_count=1, first_err_vec=2'b11, pass=0.
- N_IN=3, SETTLE=2, mode=4, correct XOR DUT; pulse start again mid-sweep and toggle mode mid-sweep -> both ignored; done after 24 cycles, pass=1.
- N_IN=3, ERR_W=2, mode=0, dut_out=~golden -> err_count saturates at 3 (not 8); first_err_vec=3'b000; pass=0.
- Deassert-then-assert rst_n at vector 2 of a sweep -> all outputs immediately return to reset values; a new start then completes a normal sweep.
